// File: rtl/keccak_pkg.sv
// ============================================================================
// keccak_pkg : shared Keccak constants (rho offset table, pi coordinate map)
// Revision   : 1.0
// ============================================================================
`default_nettype none

package keccak_pkg;

    // FIPS-202 rho offsets indexed [x][y]; reduce modulo the lane width at use.
    localparam int RHO_OFFSET [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    function automatic logic [2:0] pi_dest_y(input logic [2:0] x, input logic [2:0] y);
        return 3'((2 * int'(x) + 3 * int'(y)) % 5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_lane_rotl.sv
// ============================================================================
// keccak_lane_rotl : combinational lane rotate-left by a runtime amount
// Revision         : 1.0
// ============================================================================
`default_nettype none

module keccak_lane_rotl #(
    parameter int LANE_W = 64,
    parameter int AMT_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
    input  logic [LANE_W-1:0] lane,
    input  logic [AMT_W-1:0]  amount,
    output logic [LANE_W-1:0] rotated
);

    // A right shift by the full lane width yields zero, covering amount == 0.
    assign rotated = (lane << amount) | (lane >> (LANE_W - int'(amount)));

endmodule

`default_nettype wire

// File: rtl/keccak_rho_pi_seq.sv
// ============================================================================
// keccak_rho_pi_seq : sequential rho (+ optional pi) engine, LANES_PER_CYC
//                     lanes per cycle, valid/ready on both sides
// Revision          : 1.0
// ============================================================================
`default_nettype none

module keccak_rho_pi_seq
    import keccak_pkg::*;
#(
    parameter int LANE_W        = 64,
    parameter int LANES_PER_CYC = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           pi_en_i,
    input  logic [4:0][4:0][LANE_W-1:0]    state_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [4:0][4:0][LANE_W-1:0]    state_o,
    output logic                           busy_o
);

    localparam int N_CYC = 25 / LANES_PER_CYC;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam int AMT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

    typedef logic [4:0][4:0][LANE_W-1:0] state_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t              r_state;
    fsm_t              w_next;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_in_buf;
    state_t            r_out_buf;
    logic              r_pi_mode;
    logic              w_accept;

    logic [LANE_W-1:0] w_lane_in  [LANES_PER_CYC];
    logic [LANE_W-1:0] w_lane_rot [LANES_PER_CYC];
    logic [AMT_W-1:0]  w_amt      [LANES_PER_CYC];
    logic [2:0]        w_dx       [LANES_PER_CYC];
    logic [2:0]        w_dy       [LANES_PER_CYC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // in_ready_o depends combinationally on out_ready_i only, never on in_valid_i.
    always_comb begin
        w_next      = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) w_next = S_PROC;
            end
            S_PROC: begin
                busy_o = 1'b1;
                if (r_cnt == CNT_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) w_next = in_valid_i ? S_PROC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid_i && in_ready_o;

    // Lane group for this cycle: flat index idx = x + 5y = cnt*L + k.
    always_comb begin
        int         idx;
        logic [2:0] lx;
        logic [2:0] ly;
        idx = 0;
        lx  = 3'd0;
        ly  = 3'd0;
        for (int k = 0; k < LANES_PER_CYC; k++) begin
            idx          = int'(r_cnt) * LANES_PER_CYC + k;
            lx           = 3'(idx % 5);
            ly           = 3'(idx / 5);
            w_lane_in[k] = r_in_buf[lx][ly];
            w_amt[k]     = AMT_W'(RHO_OFFSET[lx][ly] % LANE_W);
            w_dx[k]      = r_pi_mode ? ly : lx;
            w_dy[k]      = r_pi_mode ? pi_dest_y(lx, ly) : ly;
        end
    end

    for (genvar k = 0; k < LANES_PER_CYC; k++) begin : g_lane
        keccak_lane_rotl #(
            .LANE_W (LANE_W),
            .AMT_W  (AMT_W)
        ) u_rotl (
            .lane    (w_lane_in[k]),
            .amount  (w_amt[k]),
            .rotated (w_lane_rot[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_in_buf  <= '0;
            r_out_buf <= '0;
            r_pi_mode <= 1'b0;
        end else if (w_accept) begin
            r_in_buf  <= state_i;
            r_pi_mode <= pi_en_i;
            r_cnt     <= '0;
        end else if (r_state == S_PROC) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            for (int k = 0; k < LANES_PER_CYC; k++) begin
                r_out_buf[w_dx[k]][w_dy[k]] <= w_lane_rot[k];
            end
        end
    end

    assign state_o = r_out_buf;

endmodule

`default_nettype wire

// File: tb/tb_keccak_rho_pi_seq.sv
// ============================================================================
// tb_keccak_rho_pi_seq : directed bench over L=1/5/25 (w=64) and L=5 (w=8)
// Revision             : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keccak_rho_pi_seq;

    typedef logic [4:0][4:0][63:0] st64_t;
    typedef logic [4:0][4:0][7:0]  st8_t;

    // Rho offsets, index 5*x+y
    localparam int RHO_XY [25] = '{ 0, 36,  3, 41, 18,
                                    1, 44, 10, 45,  2,
                                   62,  6, 43, 15, 61,
                                   28, 55, 25, 21, 56,
                                   27, 20, 39,  8, 14};
    // dut order: L=1, L=5, L=25 (w=64), L=5 (w=8)
    localparam int EXP_LAT [4] = '{25, 5, 1, 5};

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       pi_en     = 1'b0;
    logic       out_ready = 1'b0;
    st64_t      state_in  = '0;
    st8_t       state8_in = '0;
    logic [3:0] rdy, vld, bsy;
    st64_t      so1, so5, so25;
    st8_t       so8;

    st64_t res64 [3];
    st8_t  res8;
    int    lat [4];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    keccak_rho_pi_seq #(.LANE_W(64), .LANES_PER_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .pi_en_i(pi_en),
        .state_i(state_in), .out_valid_o(vld[0]), .out_ready_i(out_ready), .state_o(so1), .busy_o(bsy[0]));
    keccak_rho_pi_seq #(.LANE_W(64), .LANES_PER_CYC(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .pi_en_i(pi_en),
        .state_i(state_in), .out_valid_o(vld[1]), .out_ready_i(out_ready), .state_o(so5), .busy_o(bsy[1]));
    keccak_rho_pi_seq #(.LANE_W(64), .LANES_PER_CYC(25)) dut25 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[2]), .pi_en_i(pi_en),
        .state_i(state_in), .out_valid_o(vld[2]), .out_ready_i(out_ready), .state_o(so25), .busy_o(bsy[2]));
    keccak_rho_pi_seq #(.LANE_W(8), .LANES_PER_CYC(5)) dut8 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[3]), .pi_en_i(pi_en),
        .state_i(state8_in), .out_valid_o(vld[3]), .out_ready_i(out_ready), .state_o(so8), .busy_o(bsy[3]));

    function automatic logic [63:0] rotl64(input logic [63:0] v, input int r);
        return (r == 0) ? v : ((v << r) | (v >> (64 - r)));
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
        return (r == 0) ? v : ((v << r) | (v >> (8 - r)));
    endfunction

    function automatic st64_t model64(input st64_t s, input logic m);
        st64_t e = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                if (m) e[y][(2 * x + 3 * y) % 5] = rotl64(s[x][y], RHO_XY[5 * x + y] % 64);
                else   e[x][y]                   = rotl64(s[x][y], RHO_XY[5 * x + y] % 64);
            end
        end
        return e;
    endfunction

    function automatic st8_t model8(input st8_t s, input logic m);
        st8_t e = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                if (m) e[y][(2 * x + 3 * y) % 5] = rotl8(s[x][y], RHO_XY[5 * x + y] % 8);
                else   e[x][y]                   = rotl8(s[x][y], RHO_XY[5 * x + y] % 8);
            end
        end
        return e;
    endfunction

    function automatic st64_t pattern64(input int seed);
        st64_t s;
        for (int i = 0; i < 25; i++) begin
            s[i / 5][i % 5] = {32'(seed * 7919 + i * 32'h9E3779B9), 32'((i + 1) * 32'h01000193 + seed)};
        end
        return s;
    endfunction

    function automatic st8_t pattern8(input int seed);
        st8_t s;
        for (int i = 0; i < 25; i++) s[i / 5][i % 5] = 8'(i * 37 + seed + 1);
        return s;
    endfunction

    function automatic int diff64(input st64_t a, input st64_t b);
        for (int i = 0; i < 25; i++) if (a[i / 5][i % 5] !== b[i / 5][i % 5]) return i;
        return 0;
    endfunction

    function automatic int diff8(input st8_t a, input st8_t b);
        for (int i = 0; i < 25; i++) if (a[i / 5][i % 5] !== b[i / 5][i % 5]) return i;
        return 0;
    endfunction

    // Present one job at the next negedge; it is accepted on the following posedge.
    task automatic launch(input st64_t s, input st8_t s8, input logic m, input logic ordy);
        @(negedge clk);
        state_in  = s;
        state8_in = s8;
        pi_en     = m;
        in_valid  = 1'b1;
        out_ready = ordy;
        @(negedge clk);
    endtask

    // Called on the negedge right after the accepting edge; records first out_valid per dut.
    task automatic wait_results();
        in_valid  = 1'b0;
        state_in  = ~state_in;
        state8_in = ~state8_in;
        pi_en     = ~pi_en;
        for (int i = 0; i < 4; i++) lat[i] = -1;
        for (int n = 0; n <= 40; n++) begin
            if (lat[0] < 0 && vld[0]) begin lat[0] = n; res64[0] = so1;  end
            if (lat[1] < 0 && vld[1]) begin lat[1] = n; res64[1] = so5;  end
            if (lat[2] < 0 && vld[2]) begin lat[2] = n; res64[2] = so25; end
            if (lat[3] < 0 && vld[3]) begin lat[3] = n; res8     = so8;  end
            if (n < 40) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rdy !== 4'hF || vld !== 4'h0 || bsy !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b expected 1111/0000/0000", rdy, vld, bsy);
        end
        n_checks++;
        if (so1 !== '0 || so5 !== '0 || so25 !== '0 || so8 !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got nonzero state_o, expected all zero");
        end
        rst = 1'b0;
    endtask

    task automatic test_rho_single();
        st64_t s = '0, e = '0;
        st8_t  s8 = '0, e8 = '0;
        int    k;
        s[1][0] = 64'h1; s8[1][0] = 8'h01;
        e[1][0] = 64'h2; e8[1][0] = 8'h02;
        launch(s, s8, 1'b0, 1'b1);
        wait_results();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] !== EXP_LAT[i]) begin
                n_fail++;
                $display("FAIL rho_single latency dut%0d: got %0d expected %0d", i, lat[i], EXP_LAT[i]);
            end
            n_checks++;
            if (res64[i] !== e) begin
                n_fail++; k = diff64(res64[i], e);
                $display("FAIL rho_single state dut%0d lane[%0d][%0d]: got %h expected %h", i, k / 5, k % 5, res64[i][k / 5][k % 5], e[k / 5][k % 5]);
            end
        end
        n_checks++;
        if (lat[3] !== EXP_LAT[3] || res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL rho_single w8: got lat %0d lane[%0d][%0d]=%h expected lat %0d value %h", lat[3], k / 5, k % 5, res8[k / 5][k % 5], EXP_LAT[3], e8[k / 5][k % 5]);
        end
    endtask

    task automatic test_pi_single();
        st64_t s = '0, e = '0;
        st8_t  s8 = '0, e8 = '0;
        int    k;
        s[1][0] = 64'h1; s8[1][0] = 8'h01;
        e[0][2] = 64'h2; e8[0][2] = 8'h02;
        launch(s, s8, 1'b1, 1'b1);
        wait_results();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] !== EXP_LAT[i] || res64[i] !== e) begin
                n_fail++; k = diff64(res64[i], e);
                $display("FAIL pi_single dut%0d: got lat %0d lane[%0d][%0d]=%h expected lat %0d value %h", i, lat[i], k / 5, k % 5, res64[i][k / 5][k % 5], EXP_LAT[i], e[k / 5][k % 5]);
            end
        end
        n_checks++;
        if (lat[3] !== EXP_LAT[3] || res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL pi_single w8: got lat %0d lane[%0d][%0d]=%h expected lat %0d value %h", lat[3], k / 5, k % 5, res8[k / 5][k % 5], EXP_LAT[3], e8[k / 5][k % 5]);
        end
    endtask

    task automatic test_all_ones();
        st64_t s, e;
        st8_t  s8, e8;
        int    k;
        for (int i = 0; i < 25; i++) begin s[i / 5][i % 5] = 64'h1; s8[i / 5][i % 5] = 8'h01; end
        e  = model64(s, 1'b0);
        e8 = model8(s8, 1'b0);
        launch(s, s8, 1'b0, 1'b1);
        wait_results();
        n_checks++;
        if (res64[1][0][0] !== 64'h1 || res64[1][0][1] !== 64'h0000001000000000 ||
            res64[1][2][0] !== 64'h4000000000000000 || res64[1][4][4] !== 64'h0000000000004000) begin
            n_fail++;
            $display("FAIL all_ones key lanes: got %h %h %h %h expected 1 1000000000 4000000000000000 4000",
                     res64[1][0][0], res64[1][0][1], res64[1][2][0], res64[1][4][4]);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res64[i] !== e) begin
                n_fail++; k = diff64(res64[i], e);
                $display("FAIL all_ones state dut%0d lane[%0d][%0d]: got %h expected %h", i, k / 5, k % 5, res64[i][k / 5][k % 5], e[k / 5][k % 5]);
            end
        end
        n_checks++;
        if (res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL all_ones w8 lane[%0d][%0d]: got %h expected %h", k / 5, k % 5, res8[k / 5][k % 5], e8[k / 5][k % 5]);
        end
    endtask

    task automatic test_w8_lane();
        st64_t s = '0;
        st8_t  s8 = '0, e8 = '0;
        int    k;
        s8[0][1] = 8'h01;
        e8[0][1] = 8'h10;
        launch(s, s8, 1'b0, 1'b1);
        wait_results();
        n_checks++;
        if (lat[3] !== 5 || res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL w8_lane: got lat %0d lane[%0d][%0d]=%h expected lat 5 value %h", lat[3], k / 5, k % 5, res8[k / 5][k % 5], e8[k / 5][k % 5]);
        end
        n_checks++;
        if (res64[1] !== '0) begin
            n_fail++;
            $display("FAIL w8_lane zero64: got nonzero result for zero input, expected all zero");
        end
    endtask

    task automatic test_pi_pattern();
        st64_t s, e;
        st8_t  s8, e8;
        int    k;
        s  = pattern64(3);
        s8 = pattern8(3);
        e  = model64(s, 1'b1);
        e8 = model8(s8, 1'b1);
        launch(s, s8, 1'b1, 1'b1);
        wait_results();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res64[i] !== e) begin
                n_fail++; k = diff64(res64[i], e);
                $display("FAIL pi_pattern dut%0d lane[%0d][%0d]: got %h expected %h", i, k / 5, k % 5, res64[i][k / 5][k % 5], e[k / 5][k % 5]);
            end
        end
        n_checks++;
        if (res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL pi_pattern w8 lane[%0d][%0d]: got %h expected %h", k / 5, k % 5, res8[k / 5][k % 5], e8[k / 5][k % 5]);
        end
    endtask

    task automatic test_back_to_back();
        st64_t s, e, s2, e2;
        st8_t  s8, e8, s28, e28;
        int    k;
        int    bad_hold = 0;
        s   = pattern64(11);  s8  = pattern8(11);
        s2  = pattern64(29);  s28 = pattern8(29);
        e   = model64(s, 1'b0);  e8  = model8(s8, 1'b0);
        e2  = model64(s2, 1'b1); e28 = model8(s28, 1'b1);
        launch(s, s8, 1'b0, 1'b0);
        wait_results();
        n_checks++;
        if (lat[1] !== 5 || res64[1] !== e || lat[0] !== 25) begin
            n_fail++;
            $display("FAIL stall_first: got lat5 %0d lat1 %0d lane00 %h expected 5 25 %h", lat[1], lat[0], res64[1][0][0], e[0][0]);
        end
        for (int c = 0; c < 10; c++) begin
            state_in  = pattern64(100 + c);
            state8_in = pattern8(100 + c);
            pi_en     = c[0];
            in_valid  = 1'b1;
            #1;
            if (rdy !== 4'h0) bad_hold++;
            @(negedge clk);
            if (vld !== 4'hF || so1 !== e || so5 !== e || so25 !== e || so8 !== e8) bad_hold++;
        end
        n_checks++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad cycles (vld=%b rdy=%b) expected 0", bad_hold, vld, rdy);
        end
        state_in  = s2;
        state8_in = s28;
        pi_en     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (rdy !== 4'hF) begin
            n_fail++;
            $display("FAIL release_ready: got %b expected 1111", rdy);
        end
        @(negedge clk);
        n_checks++;
        if (vld !== 4'h0 || bsy !== 4'hF) begin
            n_fail++;
            $display("FAIL back_to_back_accept: got vld=%b busy=%b expected 0000/1111", vld, bsy);
        end
        wait_results();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] !== EXP_LAT[i] || res64[i] !== e2) begin
                n_fail++; k = diff64(res64[i], e2);
                $display("FAIL back_to_back dut%0d: got lat %0d lane[%0d][%0d]=%h expected lat %0d value %h", i, lat[i], k / 5, k % 5, res64[i][k / 5][k % 5], EXP_LAT[i], e2[k / 5][k % 5]);
            end
        end
        n_checks++;
        if (res8 !== e28) begin
            n_fail++; k = diff8(res8, e28);
            $display("FAIL back_to_back w8 lane[%0d][%0d]: got %h expected %h", k / 5, k % 5, res8[k / 5][k % 5], e28[k / 5][k % 5]);
        end
    endtask

    task automatic test_reset_mid();
        st64_t s = '0, e = '0;
        st8_t  s8 = '0, e8 = '0;
        int    k;
        int    spurious = 0;
        launch(pattern64(7), pattern8(7), 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bsy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b expected 1", bsy[1]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (vld !== 4'h0 || rdy !== 4'hF || bsy !== 4'h0 || so1 !== '0 || so5 !== '0 || so25 !== '0 || so8 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got vld=%b rdy=%b busy=%b lane00=%h expected 0000/1111/0000 zero state", vld, rdy, bsy, so5[0][0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (vld !== 4'h0) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL mid_no_valid: got %0d valid cycles expected 0", spurious);
        end
        s[1][0] = 64'h1; s8[1][0] = 8'h01;
        e[0][2] = 64'h2; e8[0][2] = 8'h02;
        launch(s, s8, 1'b1, 1'b1);
        wait_results();
        n_checks++;
        if (lat[1] !== 5 || res64[1] !== e) begin
            n_fail++; k = diff64(res64[1], e);
            $display("FAIL after_reset: got lat %0d lane[%0d][%0d]=%h expected lat 5 value %h", lat[1], k / 5, k % 5, res64[1][k / 5][k % 5], e[k / 5][k % 5]);
        end
        n_checks++;
        if (res8 !== e8) begin
            n_fail++; k = diff8(res8, e8);
            $display("FAIL after_reset w8 lane[%0d][%0d]: got %h expected %h", k / 5, k % 5, res8[k / 5][k % 5], e8[k / 5][k % 5]);
        end
    endtask

    initial begin
        test_reset();
        test_rho_single();
        test_pi_single();
        test_all_ones();
        test_w8_lane();
        test_pi_pattern();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
